// File: rtl/bc_miner.sv
// bc_miner: Bitcoin proof-of-work nonce search.
//
// On an accepted start the current block (midstate, header tail, target) is
// snapshotted. The nonce range [0, 2^COUNTBITS) is swept in batches of NUM_CORES
// nonces. Every core runs both SHA-256 compressions iteratively, one round every
// ROUND_PIPELINE_DEPTH clocks. Passing nonces are then written to the nonce
// buffer in ascending order.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_chip_start        single-cycle mining request (IDLE with i_blk_valid only)
//   o_chip_busy         search in progress
//   o_chip_done         search finished, held until the next accepted start
//   i_blk_valid         block store holds a valid block
//   i_blk_midstate      SHA-256 midstate, H0 in [255:224]
//   i_blk_tail          header words 16..18, W0 in [95:64]
//   i_blk_target        pass threshold for byteswap(H7)
//   o_nb_wr_en          nonce buffer write strobe
//   o_nb_nonce          nonce being written (0 when not writing)
//   i_nb_full           nonce buffer cannot accept a write this cycle
module bc_miner #(
    parameter int unsigned COUNTBITS            = 4,
    parameter int unsigned ROUND_PIPELINE_DEPTH = 3,
    parameter int unsigned NUM_CORES            = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_chip_start,
    output logic         o_chip_busy,
    output logic         o_chip_done,
    input  logic         i_blk_valid,
    input  logic [255:0] i_blk_midstate,
    input  logic [95:0]  i_blk_tail,
    input  logic [31:0]  i_blk_target,
    output logic         o_nb_wr_en,
    output logic [31:0]  o_nb_nonce,
    input  logic         i_nb_full
);

    localparam logic [32:0]  NonceLimit = 33'd1 << COUNTBITS;
    localparam logic [7:0]   LastSub    = 8'(ROUND_PIPELINE_DEPTH - 1);
    localparam logic [255:0] Iv = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [2047:0] KTab = {
        256'h428a2f98_71374491_b5c0fbcf_e9b5dba5_3956c25b_59f111f1_923f82a4_ab1c5ed5,
        256'hd807aa98_12835b01_243185be_550c7dc3_72be5d74_80deb1fe_9bdc06a7_c19bf174,
        256'he49b69c1_efbe4786_0fc19dc6_240ca1cc_2de92c6f_4a7484aa_5cb0a9dc_76f988da,
        256'h983e5152_a831c66d_b00327c8_bf597fc7_c6e00bf3_d5a79147_06ca6351_14292967,
        256'h27b70a85_2e1b2138_4d2c6dfc_53380d13_650a7354_766a0abb_81c2c92e_92722c85,
        256'ha2bfe8a1_a81a664b_c24b8b70_c76c51a3_d192e819_d6990624_f40e3585_106aa070,
        256'h19a4c116_1e376c08_2748774c_34b0bcb5_391c0cb3_4ed8aa4a_5b9cca4f_682e6ff3,
        256'h748f82ee_78a5636f_84c87814_8cc70208_90befffa_a4506ceb_bef9a3f7_c67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [31:0] k_of(input logic [5:0] t);
        return KTab[2047 - 32 * int'(t) -: 32];
    endfunction

    typedef enum logic [1:0] {StIdle, StHash, StDrain} state_e;

    state_e               r_state;
    state_e               w_state_d;
    logic [255:0]         r_mid;
    logic [95:0]          r_tail;
    logic [31:0]          r_target;
    logic [31:0]          r_base;
    logic [7:0]           r_round;     // 0..127 = rounds, 128 = final additions
    logic [7:0]           r_sub;
    logic [NUM_CORES-1:0] r_pass;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_accept;
    logic                 w_load;
    logic                 w_step;
    logic                 w_latch;
    logic                 w_wr;
    logic                 w_batch_done;
    logic                 w_more;
    logic [31:0]          w_base_next;
    logic [31:0]          w_ld_base;
    logic [255:0]         w_ld_mid;
    logic [95:0]          w_ld_tail;
    logic [NUM_CORES-1:0] w_pass_vec;
    logic [NUM_CORES-1:0] w_onehot;
    logic [31:0]          w_idx;

    assign w_step      = (r_state == StHash) && !r_round[7] && (r_sub == LastSub);
    assign w_base_next = r_base + 32'(NUM_CORES);
    assign w_more      = {1'b0, w_base_next} < NonceLimit;
    // The accepting edge loads cores straight from the block store inputs.
    assign w_ld_base   = w_accept ? '0 : w_base_next;
    assign w_ld_mid    = w_accept ? i_blk_midstate : r_mid;
    assign w_ld_tail   = w_accept ? i_blk_tail : r_tail;

    // Lowest pending core index is written first.
    always_comb begin
        w_idx    = '0;
        w_onehot = '0;
        for (int i = int'(NUM_CORES) - 1; i >= 0; i--) begin
            if (r_pass[i]) begin
                w_idx       = 32'(i);
                w_onehot    = '0;
                w_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_accept     = 1'b0;
        w_load       = 1'b0;
        w_latch      = 1'b0;
        w_wr         = 1'b0;
        w_batch_done = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_chip_start && i_blk_valid) begin
                    w_accept  = 1'b1;
                    w_load    = 1'b1;
                    w_state_d = StHash;
                end
            end
            StHash: begin
                if (r_round == 8'd128) begin
                    w_latch = 1'b1;
                    if (w_pass_vec == '0) begin
                        w_batch_done = 1'b1;
                    end else begin
                        w_state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (!i_nb_full) begin
                    w_wr = 1'b1;
                    if ((r_pass & ~w_onehot) == '0) begin
                        w_batch_done = 1'b1;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
        if (w_batch_done) begin
            if (w_more) begin
                w_load    = 1'b1;
                w_state_d = StHash;
            end else begin
                w_state_d = StIdle;
            end
        end
        o_nb_wr_en = w_wr;
        o_nb_nonce = w_wr ? (r_base + w_idx) : '0;
    end

    assign o_chip_busy = r_busy;
    assign o_chip_done = r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_mid    <= '0;
            r_tail   <= '0;
            r_target <= '0;
            r_base   <= '0;
            r_round  <= '0;
            r_sub    <= '0;
            r_pass   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            if (w_accept) begin
                r_mid    <= i_blk_midstate;
                r_tail   <= i_blk_tail;
                r_target <= i_blk_target;
                r_busy   <= 1'b1;
                r_done   <= 1'b0;
            end
            if (w_load) begin
                r_base  <= w_ld_base;
                r_round <= '0;
                r_sub   <= '0;
            end else if (r_state == StHash && !r_round[7]) begin
                if (r_sub == LastSub) begin
                    r_sub   <= '0;
                    r_round <= r_round + 8'd1;
                end else begin
                    r_sub <= r_sub + 8'd1;
                end
            end
            if (w_latch) begin
                r_pass <= w_pass_vec;
            end else if (w_wr) begin
                r_pass <= r_pass & ~w_onehot;
            end
            if (w_batch_done && !w_more) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
        logic [31:0] r_st [8];
        logic [31:0] r_w  [16];   // r_w[0] is the current round's schedule word
        logic [31:0] w_rnd [8];
        logic [31:0] w_t1;
        logic [31:0] w_t2;
        logic [31:0] w_wnext;
        logic [31:0] w_nonce;

        always_comb begin
            w_t1 = r_st[7] + bsig1(r_st[4]) + ((r_st[4] & r_st[5]) ^ (~r_st[4] & r_st[6]))
                 + k_of(r_round[5:0]) + r_w[0];
            w_t2 = bsig0(r_st[0])
                 + ((r_st[0] & r_st[1]) ^ (r_st[0] & r_st[2]) ^ (r_st[1] & r_st[2]));
            w_rnd[0] = w_t1 + w_t2;
            w_rnd[1] = r_st[0];
            w_rnd[2] = r_st[1];
            w_rnd[3] = r_st[2];
            w_rnd[4] = r_st[3] + w_t1;
            w_rnd[5] = r_st[4];
            w_rnd[6] = r_st[5];
            w_rnd[7] = r_st[6];
            w_wnext  = ssig1(r_w[14]) + r_w[9] + ssig0(r_w[1]) + r_w[0];
        end

        assign w_nonce = w_ld_base + 32'(gi);

        // Datapath needs no reset: every batch starts with a full load.
        always_ff @(posedge clk) begin
            if (w_load) begin
                for (int j = 0; j < 8; j++) begin
                    r_st[j] <= w_ld_mid[255 - 32 * j -: 32];
                end
                r_w[0]  <= w_ld_tail[95:64];
                r_w[1]  <= w_ld_tail[63:32];
                r_w[2]  <= w_ld_tail[31:0];
                r_w[3]  <= bswap(w_nonce);
                r_w[4]  <= 32'h8000_0000;
                for (int j = 5; j < 15; j++) begin
                    r_w[j] <= '0;
                end
                r_w[15] <= 32'h0000_0280;
            end else if (w_step) begin
                if (r_round == 8'd63) begin
                    // End of first compression: h1 becomes the second message block.
                    for (int j = 0; j < 8; j++) begin
                        r_st[j] <= Iv[255 - 32 * j -: 32];
                        r_w[j]  <= r_mid[255 - 32 * j -: 32] + w_rnd[j];
                    end
                    r_w[8]  <= 32'h8000_0000;
                    for (int j = 9; j < 15; j++) begin
                        r_w[j] <= '0;
                    end
                    r_w[15] <= 32'h0000_0100;
                end else begin
                    for (int j = 0; j < 8; j++) begin
                        r_st[j] <= w_rnd[j];
                    end
                    for (int j = 0; j < 15; j++) begin
                        r_w[j] <= r_w[j + 1];
                    end
                    r_w[15] <= w_wnext;
                end
            end
        end

        // Only H7 matters for the pass test, so only its final addition is built.
        assign w_pass_vec[gi] = ({1'b0, r_base + 32'(gi)} < NonceLimit)
                              && (bswap(Iv[31:0] + r_st[7]) <= r_target);
    end

endmodule

// File: tb/tb_bc_miner.sv
module tb_bc_miner;

    localparam int NN = 16;

    localparam logic [255:0] SHA_IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [2047:0] SHA_K = {
        256'h428a2f98_71374491_b5c0fbcf_e9b5dba5_3956c25b_59f111f1_923f82a4_ab1c5ed5,
        256'hd807aa98_12835b01_243185be_550c7dc3_72be5d74_80deb1fe_9bdc06a7_c19bf174,
        256'he49b69c1_efbe4786_0fc19dc6_240ca1cc_2de92c6f_4a7484aa_5cb0a9dc_76f988da,
        256'h983e5152_a831c66d_b00327c8_bf597fc7_c6e00bf3_d5a79147_06ca6351_14292967,
        256'h27b70a85_2e1b2138_4d2c6dfc_53380d13_650a7354_766a0abb_81c2c92e_92722c85,
        256'ha2bfe8a1_a81a664b_c24b8b70_c76c51a3_d192e819_d6990624_f40e3585_106aa070,
        256'h19a4c116_1e376c08_2748774c_34b0bcb5_391c0cb3_4ed8aa4a_5b9cca4f_682e6ff3,
        256'h748f82ee_78a5636f_84c87814_8cc70208_90befffa_a4506ceb_bef9a3f7_c67178f2
    };

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic valid = 1'b0;
    logic full = 1'b0;
    logic [255:0] mid = '0;
    logic [95:0] tail = '0;
    logic [31:0] target = '0;
    logic [2:0] busy, done, wr;
    logic [2:0][31:0] nonce;

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    int wr_cyc [NN];
    int last_wr_cyc = -1;
    logic [31:0] exp_q0[$], exp_q1[$], exp_q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bc_miner u_dut (
        .clk(clk), .rst_n(rst_n), .i_chip_start(start), .o_chip_busy(busy[0]),
        .o_chip_done(done[0]), .i_blk_valid(valid), .i_blk_midstate(mid), .i_blk_tail(tail),
        .i_blk_target(target), .o_nb_wr_en(wr[0]), .o_nb_nonce(nonce[0]), .i_nb_full(full)
    );

    bc_miner #(.COUNTBITS(4), .ROUND_PIPELINE_DEPTH(3), .NUM_CORES(1)) u_dut_nc1 (
        .clk(clk), .rst_n(rst_n), .i_chip_start(start), .o_chip_busy(busy[1]),
        .o_chip_done(done[1]), .i_blk_valid(valid), .i_blk_midstate(mid), .i_blk_tail(tail),
        .i_blk_target(target), .o_nb_wr_en(wr[1]), .o_nb_nonce(nonce[1]), .i_nb_full(full)
    );

    bc_miner #(.COUNTBITS(4), .ROUND_PIPELINE_DEPTH(3), .NUM_CORES(16)) u_dut_nc16 (
        .clk(clk), .rst_n(rst_n), .i_chip_start(start), .o_chip_busy(busy[2]),
        .o_chip_done(done[2]), .i_blk_valid(valid), .i_blk_midstate(mid), .i_blk_tail(tail),
        .i_blk_target(target), .o_nb_wr_en(wr[2]), .o_nb_nonce(nonce[2]), .i_nb_full(full)
    );

    // ---------------- reference model: plain double SHA-256 ----------------
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [255:0] sha_block(input logic [255:0] st, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] t1, t2;
        logic [255:0] res;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32 * t -: 32];
        for (int t = 16; t < 64; t++)
            w[t] = w[t-16] + w[t-7]
                 + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3))
                 + (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10));
        for (int j = 0; j < 8; j++) v[j] = st[255 - 32 * j -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + SHA_K[2047 - 32 * t -: 32] + w[t];
            t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int j = 0; j < 8; j++) res[255 - 32 * j -: 32] = st[255 - 32 * j -: 32] + v[j];
        return res;
    endfunction

    function automatic logic model_pass(input logic [255:0] m, input logic [95:0] t,
                                        input logic [31:0] tg, input logic [31:0] n);
        logic [255:0] h1, h2;
        h1 = sha_block(m, {t, bswap(n), 32'h8000_0000, 320'd0, 32'h0000_0280});
        h2 = sha_block(SHA_IV, {h1, 32'h8000_0000, 192'd0, 32'h0000_0100});
        return bswap(h2[31:0]) <= tg;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    function automatic int qsize(input int k);
        case (k)
            0: return exp_q0.size();
            1: return exp_q1.size();
            default: return exp_q2.size();
        endcase
    endfunction

    function automatic logic [31:0] qpop(input int k);
        case (k)
            0: return exp_q0.pop_front();
            1: return exp_q1.pop_front();
            default: return exp_q2.pop_front();
        endcase
    endfunction

    task automatic push_expected(input logic [255:0] m, input logic [95:0] t,
                                 input logic [31:0] tg);
        for (int n = 0; n < NN; n++) begin
            if (model_pass(m, t, tg, 32'(n))) begin
                exp_q0.push_back(32'(n));
                exp_q1.push_back(32'(n));
                exp_q2.push_back(32'(n));
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin
                if (wr[k]) begin
                    check($sformatf("write_while_full[%0d]", k), longint'(full), 0);
                    if (qsize(k) == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_write[%0d]: got nonce %0d, required no write",
                                 k, nonce[k]);
                    end else begin
                        check($sformatf("nonce_order[%0d]", k), longint'(nonce[k]),
                              longint'(qpop(k)));
                    end
                    if (k == 0) begin
                        if (nonce[0] < 32'(NN)) wr_cyc[nonce[0][3:0]] = cyc;
                        last_wr_cyc = cyc;
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [255:0] rand256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(output int n0);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n0 = cyc;
    endtask

    task automatic wait_done(output int done_cyc);
        int budget = 9000;
        done_cyc = -1;
        while (budget > 0 && done != 3'b111) begin
            @(negedge clk);
            budget--;
            if (done[0] && done_cyc < 0) done_cyc = cyc;
        end
        if (done != 3'b111) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: got done=%b, required 111", done);
        end
    endtask

    // mode 0: all-pass timing, 1: backpressure, 2: start filter + block change, 3: model only
    task automatic run_block(input int mode, input logic [31:0] tg);
        int n0, dc;
        mid = rand256();
        tail = {$urandom, $urandom, $urandom};
        target = tg;
        valid = 1'b1;
        for (int i = 0; i < NN; i++) wr_cyc[i] = -1;
        push_expected(mid, tail, tg);
        do_start(n0);
        if (mode == 1) begin
            wait_cyc(n0 + 385);
            full = 1'b1;
            wait_cyc(n0 + 435);
            full = 1'b0;
        end else if (mode == 2) begin
            wait_cyc(n0 + 100);
            start = 1'b1;
            mid = rand256();
            tail = {$urandom, $urandom, $urandom};
            target = 32'h0;
            @(posedge clk);
            #1 start = 1'b0;
            valid = 1'b0;
        end
        wait_done(dc);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("missing_nonces[%0d]", k), qsize(k), 0);
            check($sformatf("busy_after_done[%0d]", k), longint'(busy[k]), 0);
        end
        if (mode == 0 || mode == 2) begin
            check("first_write_latency", wr_cyc[0] - n0, 385);
            check("second_batch_gap", wr_cyc[10] - wr_cyc[9], 386);
        end
        if (mode == 1) begin
            check("first_write_after_full", wr_cyc[0] - n0, 435);
            check("batch1_back_to_back", wr_cyc[9] - wr_cyc[0], 9);
            check("batch2_after_batch1", wr_cyc[10] - wr_cyc[9], 386);
        end
        if (mode <= 2) check("done_after_last_write", dc - last_wr_cyc, 1);
    endtask

    logic [31:0] rand_tg [4] = '{32'h0FFF_FFFF, 32'h0FFF_FFFF, 32'h3FFF_FFFF, 32'h7FFF_FFFF};

    initial begin
        logic [255:0] abc;
        int n0;
        abc = SHA_IV + 256'd0;
        abc = sha_block(SHA_IV, {32'h6162_6380, 448'd0, 32'h0000_0018});
        if (abc != 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad) begin
            $display("FAIL model_selftest: got %h", abc);
            $fatal(1, "reference model broken");
        end

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset_busy[%0d]", k), longint'(busy[k]), 0);
            check($sformatf("reset_done[%0d]", k), longint'(done[k]), 0);
            check($sformatf("reset_wr[%0d]", k), longint'(wr[k]), 0);
            check($sformatf("reset_nonce[%0d]", k), longint'(nonce[k]), 0);
        end

        // Start with no valid block is ignored.
        valid = 1'b0;
        do_start(n0);
        wait_cyc(n0 + 5);
        for (int k = 0; k < 3; k++)
            check($sformatf("start_without_valid[%0d]", k), longint'(busy[k]), 0);

        run_block(0, 32'hFFFF_FFFF);
        run_block(1, 32'hFFFF_FFFF);
        run_block(2, 32'hFFFF_FFFF);
        for (int i = 0; i < 4; i++) run_block(3, rand_tg[i]);
        run_block(3, 32'h0);

        // Reset in the middle of hashing.
        mid = rand256();
        target = 32'hFFFF_FFFF;
        valid = 1'b1;
        push_expected(mid, tail, target);
        do_start(n0);
        wait_cyc(n0 + 200);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("midrun_reset_busy[%0d]", k), longint'(busy[k]), 0);
            check($sformatf("midrun_reset_done[%0d]", k), longint'(done[k]), 0);
            check($sformatf("midrun_reset_wr[%0d]", k), longint'(wr[k]), 0);
        end
        exp_q0.delete();
        exp_q1.delete();
        exp_q2.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_cyc(cyc + 500);
        for (int k = 0; k < 3; k++)
            check($sformatf("idle_after_reset[%0d]", k), longint'(busy[k]), 0);

        run_block(0, 32'hFFFF_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bc_miner.md
# bc_miner

Bitcoin proof-of-work search engine that sits between the host chip interface, the block store and the nonce buffer. On a start command it snapshots the current block (SHA-256 midstate, header tail, target) from the block store. It evaluates double SHA-256 for every nonce in `[0, 2^COUNTBITS)` using `NUM_CORES` parallel iterative hash cores. Every passing nonce is written to the nonce buffer, and completion is signalled to the chip.

## Interface
- `COUNTBITS`, default 4: nonce search width; nonces `0 .. 2^COUNTBITS-1` are tested, upper nonce bits are zero.
- `ROUND_PIPELINE_DEPTH`, default 3: clocks per SHA-256 round in each core.
- `NUM_CORES`, default 10: parallel hash cores.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `chip_start` in 1: single-cycle request to mine the current block.
- `chip_busy` out 1: mining in progress.
- `chip_done` out 1: search complete; held until the next accepted start.
- `blk_valid` in 1: block store holds a valid block.
- `blk_midstate` in 256: SHA-256 state after header bytes 0..63; word H0 in bits [255:224].
- `blk_tail` in 96: header words 16..18 (merkle tail, time, bits) as big-endian SHA words; W0 in bits [95:64].
- `blk_target` in 32: pass threshold.
- `nb_wr_en` out 1: nonce write strobe.
- `nb_nonce` out 32: nonce value written.
- `nb_full` in 1: nonce buffer cannot accept a write this cycle.

## Operation
- States: IDLE, HASH, DRAIN.
- Reset value of every output is 0. Reset mid-operation returns the block to IDLE and discards pending results.
- Start acceptance:
  - `chip_start` is accepted only in IDLE with `blk_valid` = 1. It is ignored otherwise.
  - On accept: snapshot the `blk_*` fields, set nonce base b = 0, clear `chip_done`, set `chip_busy`, enter HASH.
- HASH assignment:
  - Core i tests nonce b+i.
  - A core whose nonce is ≥ 2^COUNTBITS is inactive and never reports a pass.
- Compression 1:
  - Initial state = midstate.
  - W0..W2 = tail, W3 = byteswap32(nonce), W4 = 0x80000000, W5..W14 = 0, W15 = 0x00000280.
  - h1 = midstate + compress (per-word mod 2^32).
- Compression 2:
  - Initial state = standard SHA-256 IV.
  - W0..W7 = h1, W8 = 0x80000000, W9..W14 = 0, W15 = 0x00000100.
  - H = IV + compress.
- Message schedule is generated on the fly with a 16-word window per core. Standard SHA-256 K constants and functions; all arithmetic is mod 2^32.
- Pass condition: byteswap32(H7) ≤ `blk_target` (unsigned).
- After both compressions, passing cores' nonces are latched and the block enters DRAIN.
- DRAIN:
  - Passing nonces are written one per cycle in ascending core index (ascending nonce).
  - `nb_wr_en` is asserted only when `nb_full` = 0. A write is never dropped; it waits while full.
- After the drain:
  - b += NUM_CORES.
  - If b < 2^COUNTBITS, the next batch enters HASH.
  - Otherwise `chip_busy` = 0, `chip_done` = 1, and the block returns to IDLE.
- If a batch has no passes, DRAIN lasts zero cycles.

## Timing
- DELAY = 128·ROUND_PIPELINE_DEPTH + 1 clocks (385 at default).
- Batch timing:
  - Cores load on the start-accepting edge (or the batch-start edge).
  - 128 rounds take ROUND_PIPELINE_DEPTH clocks each, plus one clock for the final additions.
  - Results are valid DELAY edges later.
- With `nb_full` = 0, the first write of a batch is asserted in the cycle following result-valid. Further writes are back-to-back.
- The next batch loads on the edge after the batch's last write, or on the result-valid edge if the batch has no passes.
- `chip_busy` rises on the edge that accepts start.
- `chip_done` rises and `chip_busy` falls together, on the edge completing the last write of the final batch.
- At default parameters there are 2 batches (nonces 0–9, then 10–15), so the minimum search time is ≈ 2·DELAY plus the write cycles.

## Test plan
- Reset check: assert `rst_n` = 0 mid-HASH → `chip_busy`, `chip_done`, `nb_wr_en` are 0 immediately. After release, no writes occur until a new start.
- All-pass case:
  - Stimulus: `blk_target` = 0xFFFFFFFF, defaults, start.
  - Required: exactly 16 writes, nonces 0..15 ascending.
  - Required: first write 385 clocks after the start edge.
  - Required: `chip_done` = 1 after the nonce-15 write.
- Reference-model case:
  - Stimulus: random midstate/tail, `blk_target` = 0x0FFFFFFF.
  - Required: the written nonce set equals the C/SV double-SHA model's passing set, in order.
  - Required: the model is also checked at `blk_target` = 0, where only nonces with byteswap(H7) = 0 may be written.
- Backpressure:
  - Stimulus: all-pass target, `nb_full` held high for 50 cycles at the first result.
  - Required: no write while full, no nonce lost or duplicated.
  - Required: the second batch starts only after the first batch's writes are complete.
- Start filtering: `chip_start` while busy, or with `blk_valid` = 0 → ignored. Changing `blk_*` mid-search does not change the results.
- Parameter sweep: NUM_CORES = 1 and NUM_CORES = 16 with COUNTBITS = 4 → same 16 nonces as the all-pass case, with 16 and 1 batches respectively.
